// File: rtl/serial_stim_gen.sv
// serial_stim_gen: loads a parallel word and shifts its low L bits out MSB
// first on x, optionally replaying the frame back-to-back, and counts
// completed frames. All outputs come straight from registers.
module serial_stim_gen (
    input  logic       cp,
    input  logic       rd,
    input  logic       load,
    input  logic [7:0] din,
    input  logic [3:0] len,
    input  logic       rep,
    output logic       x,
    output logic       x_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_word;
    logic [3:0] r_len;
    logic [2:0] r_idx;
    logic       r_x;
    logic       r_xValid;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_frameCnt;

    logic [3:0] w_effLen;
    logic [2:0] w_lastIdx;
    logic [2:0] w_replayIdx;
    logic [2:0] w_nextIdx;

    // Lengths of 0 or above 8 mean a full byte; indices are length minus one.
    always_comb begin
        w_effLen    = ((len == 4'd0) || (len > 4'd8)) ? 4'd8 : len;
        w_lastIdx   = 3'(w_effLen - 4'd1);
        w_replayIdx = 3'(r_len - 4'd1);
        w_nextIdx   = 3'(r_idx - 3'd1);
    end

    // Frame FSM: capture in IDLE, shift one bit per cycle, replay or finish.
    always_ff @(posedge cp) begin
        if (rd) begin
            r_state    <= S_IDLE;
            r_word     <= 8'd0;
            r_len      <= 4'd0;
            r_idx      <= 3'd0;
            r_x        <= 1'b0;
            r_xValid   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_frameCnt <= 8'd0;
        end else begin
            if (r_done) begin
                r_frameCnt <= r_frameCnt + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    r_x      <= 1'b0;
                    r_xValid <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    if (load) begin
                        r_word   <= din;
                        r_len    <= w_effLen;
                        r_idx    <= w_lastIdx;
                        r_x      <= din[w_lastIdx];
                        r_xValid <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_idx != 3'd0) begin
                        r_idx    <= w_nextIdx;
                        r_x      <= r_word[w_nextIdx];
                        r_xValid <= 1'b1;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end else if (rep) begin
                        r_idx    <= w_replayIdx;
                        r_x      <= r_word[w_replayIdx];
                        r_xValid <= 1'b1;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b1;
                    end else begin
                        r_x      <= 1'b0;
                        r_xValid <= 1'b0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_x      <= 1'b0;
                    r_xValid <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_x      <= 1'b0;
                    r_xValid <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign x         = r_x;
    assign x_valid   = r_xValid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_serial_stim_gen.sv
// tb_serial_stim_gen: drives directed and random frames into serial_stim_gen
// and compares every output, every cycle, against a frame-level model.
module tb_serial_stim_gen;

    logic       cp = 1'b0;
    logic       rd;
    logic       load;
    logic [7:0] din;
    logic [3:0] len;
    logic       rep;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;

    int         nChecks = 0;
    int         nPass   = 0;
    logic [7:0] expCnt  = 8'd0;

    serial_stim_gen dut (
        .cp        (cp),
        .rd        (rd),
        .load      (load),
        .din       (din),
        .len       (len),
        .rep       (rep),
        .x         (x),
        .x_valid   (x_valid),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 cp = ~cp;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        nChecks++;
        if (observed === expected) nPass++;
        else $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    endtask

    // Number of bits a frame carries for a given len input.
    function automatic int effLen(input logic [3:0] l);
        return ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
    endfunction

    // Quiet-state check: nothing on the line and the expected frame count.
    task automatic checkIdle(input string tag);
        checkOutput({tag, ".x"},       8'(x),       8'd0);
        checkOutput({tag, ".x_valid"}, 8'(x_valid), 8'd0);
        checkOutput({tag, ".busy"},    8'(busy),    8'd0);
        checkOutput({tag, ".done"},    8'(done),    8'd0);
        checkOutput({tag, ".cnt"},     frame_cnt,   expCnt);
    endtask

    // Start a frame from IDLE, replay it reps times, then follow DONE and IDLE.
    // Inputs are driven just after a falling edge, outputs are sampled on it.
    task automatic applyStimulus(input logic [7:0] w, input logic [3:0] l,
                                 input int reps, input bit noise);
        int  fl;
        int  total;
        int  b;
        bit  expDone;
        fl    = effLen(l);
        total = (reps + 1) * fl;
        load  = 1'b1;
        din   = w;
        len   = l;
        rep   = 1'($urandom);
        for (int k = 0; k < total; k++) begin
            @(negedge cp);
            b       = fl - 1 - (k % fl);
            expDone = (k >= fl) && ((k % fl) == 0);
            checkOutput("shift.x",       8'(x),       8'(w[b]));
            checkOutput("shift.x_valid", 8'(x_valid), 8'd1);
            checkOutput("shift.busy",    8'(busy),    8'd1);
            checkOutput("shift.done",    8'(done),    8'(expDone));
            checkOutput("shift.cnt",     frame_cnt,   expCnt);
            if (expDone) expCnt = expCnt + 8'd1;
            load = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                din = 8'($urandom);
                len = 4'($urandom);
            end
            if ((k % fl) == fl - 1) rep = ((k / fl) < reps);
            else                    rep = 1'($urandom);
        end
        @(negedge cp);
        checkOutput("done.x",       8'(x),       8'd0);
        checkOutput("done.x_valid", 8'(x_valid), 8'd0);
        checkOutput("done.busy",    8'(busy),    8'd1);
        checkOutput("done.done",    8'(done),    8'd1);
        checkOutput("done.cnt",     frame_cnt,   expCnt);
        expCnt = expCnt + 8'd1;
        load   = noise ? 1'($urandom) : 1'b1;
        din    = 8'($urandom);
        len    = 4'($urandom);
        rep    = 1'($urandom);
        @(negedge cp);
        checkIdle("idle");
        load = 1'b0;
    endtask

    initial begin
        rd   = 1'b1;
        load = 1'b1;
        din  = 8'hA5;
        len  = 4'd8;
        rep  = 1'b1;
        repeat (2) @(negedge cp);
        checkIdle("reset");
        rd   = 1'b0;
        load = 1'b0;
        @(negedge cp);
        checkIdle("postreset");

        // Directed frames: full byte, short frame, len=0 as 8, replays.
        applyStimulus(8'hB4, 4'd8, 0, 1'b0);
        applyStimulus(8'h05, 4'd3, 0, 1'b0);
        applyStimulus(8'h81, 4'd0, 0, 1'b0);
        applyStimulus(8'h02, 4'd2, 2, 1'b1);
        applyStimulus(8'h3C, 4'd13, 1, 1'b1);

        // Random frames with noise on load/din/len/rep mid-frame.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(8'($urandom), 4'($urandom), int'($urandom_range(0, 2)), 1'b1);
        end

        // Abort an 8-bit frame at its fourth bit.
        load = 1'b1;
        din  = 8'hF0;
        len  = 4'd8;
        rep  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge cp);
            checkOutput("abort.x", 8'(x), 8'(k < 4));
            load = 1'b0;
            if (k == 3) rd = 1'b1;
        end
        @(negedge cp);
        expCnt = 8'd0;
        checkIdle("abort");
        rd = 1'b0;

        // Load accepted on the first edge after reset release, then wrap test.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'($urandom), 4'd1, 0, 1'b0);
        end
        checkOutput("wrap.cnt", frame_cnt, 8'd0);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
